// File: rtl/mips_div_pkg.sv
// Shared constants and state encoding for the iterative MIPS divider.
// Imported by mips_iter_divider and its restoring-step datapath.
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIXUP
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Ports: rem_i/dvsr_i/bit_i in; rem_o (next partial remainder), qbit_o out.
module div_step
    import mips_div_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] dvsr_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    assign shifted = {rem_i, bit_i};
    // One extra bit so a borrow shows up as a negative trial.
    assign trial   = shifted - {1'b0, dvsr_i};
    assign qbit_o  = ~trial[W];
    assign rem_o   = trial[W] ? shifted[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/mips_iter_divider.sv
// Multi-cycle DIV/DIVU unit: restoring, one quotient bit per cycle.
// Ports: clk, rst_n, start, is_signed, dividend, divisor in;
//        busy, done, quotient (LO), remainder (HI), div_by_zero out.
module mips_iter_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    // abs(min int) wraps to itself, which reads correctly as unsigned.
    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

    div_step #(
        .W(WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .dvsr_i(dvsr_q),
        .bit_i (quo_q[WIDTH-1]),
        .rem_o (step_rem),
        .qbit_o(step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q     <= '0;
                        quo_q     <= a_mag;
                        dvsr_q    <= b_mag;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dbz_q     <= (divisor == '0);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ITER;
                    end
                end
                ITER: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_qbit};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    // On divide-by-zero the magnitude remainder is |dividend|;
                    // re-applying the dividend sign restores the original
                    // value, so only the quotient negation must be blocked.
                    quotient_q <= (neg_quo_q && !dbz_q)
                                  ? (~quo_q + 1'b1) : quo_q;
                    remainder_q <= neg_rem_q
                                   ? (~rem_q + 1'b1) : rem_q;
                    div_by_zero_q <= dbz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mips_iter_divider.sv
// Scoreboard bench for mips_iter_divider: random and corner DIV/DIVU ops
// checked against an arithmetic reference model.
module tb_mips_iter_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   busy_run;

    mips_iter_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endfunction

    // Reference: MIPS semantics from plain arithmetic.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                   logic s);
        exp_t   e;
        longint sa;
        longint sb_v;
        e.dbz = (b == 0);
        e.cyc = 0;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (s) begin
            sa   = longint'($signed(a));
            sb_v = longint'($signed(b));
            e.q  = 32'(sa / sb_v);
            e.r  = 32'(sa % sb_v);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Busy must stay high for exactly 33 consecutive sampled cycles.
    always @(negedge clk) begin
        if (busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            chk("busy_len", busy_run, 32'd33);
            busy_run = 0;
        end
    end

    task automatic issue(logic [31:0] a, logic [31:0] b, logic s);
        exp_t e;
        e         = model(a, b, s);
        e.cyc     = cyc + 34;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        sb.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic op(logic [31:0] a, logic [31:0] b, logic s);
        issue(a, b, s);
        wait_idle();
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] b;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        busy_run  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(32'd100, 32'd7, 1'b0);
        op(32'hFFFF_FFF9, 32'd2, 1'b1);
        op(32'd7, 32'hFFFF_FFFE, 1'b1);
        op(32'h1234, 32'd0, 1'b0);
        op(32'hFFFF_FFF0, 32'd0, 1'b1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        op(32'hFFFF_FFFF, 32'd1, 1'b0);
        op(32'h8000_0000, 32'd0, 1'b1);

        // Start while busy must be ignored.
        issue(32'd1000, 32'd9, 1'b0);
        repeat (9) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd55;
        divisor  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start held in the done cycle gives back-to-back operations.
        issue(32'd12345, 32'd67, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("b2b_timeout", 32'd1, 32'd0);
        issue(32'hFFFF_FF00, 32'd3, 1'b1);
        wait_idle();

        // Asynchronous abort mid-operation.
        issue(32'd100, 32'd7, 1'b0);
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        busy_run = 0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        op(32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                issue(a, b, 1'($urandom));
                n = 0;
                while (!done && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) chk("rand_timeout", 32'd1, 32'd0);
                issue(b, a, 1'($urandom));
                wait_idle();
            end else begin
                op(a, b, 1'($urandom));
            end
        end

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
